// File: rtl/rc4_ksa_engine.sv
// RC4 key-scheduling engine: optional identity fill of the S-box, then the
// 256-iteration KSA swap loop against an external 1-cycle-latency 256x8 RAM.
module rc4_ksa_engine #(
    parameter int KEY_BYTES = 3,
    parameter bit FILL_EN   = 1'b1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic [8*KEY_BYTES-1:0] secret_key,
    input  logic [7:0]             mem_rdata,
    output logic [7:0]             mem_addr,
    output logic [7:0]             mem_wdata,
    output logic                   mem_we,
    output logic                   busy,
    output logic                   done
);

    localparam int KW = (KEY_BYTES > 1) ? $clog2(KEY_BYTES) : 1;
    localparam logic [KW-1:0] KLAST = KW'(KEY_BYTES - 1);

    typedef enum logic [3:0] {
        IDLE, FILL, RD_I, CAP_I, RD_J, CAP_J, WR_I, WR_J, DONE
    } state_t;

    state_t                 state;
    logic [7:0]             i;
    logic [7:0]             j;
    logic [7:0]             si;
    logic [KW-1:0]          kidx;
    logic [8*KEY_BYTES-1:0] key_reg;
    logic [7:0]             key_byte;
    logic [7:0]             j_next;

    // kidx tracks i mod KEY_BYTES; key byte 0 is the MS byte of the key
    always_comb begin
        key_byte = '0;
        for (int unsigned k = 0; k < KEY_BYTES; k++) begin
            if (kidx == k[KW-1:0]) begin
                key_byte = key_reg[8*(KEY_BYTES-1-k) +: 8];
            end
        end
    end

    always_comb begin
        j_next = j + mem_rdata + key_byte;
    end

    // Output registers are loaded with the values belonging to the state being entered
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            i         <= '0;
            j         <= '0;
            si        <= '0;
            kidx      <= '0;
            key_reg   <= '0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            mem_we    <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        key_reg   <= secret_key;
                        i         <= '0;
                        j         <= '0;
                        kidx      <= '0;
                        busy      <= 1'b1;
                        mem_addr  <= '0;
                        mem_wdata <= '0;
                        if (FILL_EN) begin
                            state  <= FILL;
                            mem_we <= 1'b1;
                        end else begin
                            state  <= RD_I;
                            mem_we <= 1'b0;
                        end
                    end
                end
                FILL: begin
                    i <= i + 8'd1;
                    if (i == 8'hFF) begin
                        state     <= RD_I;
                        mem_addr  <= '0;
                        mem_wdata <= '0;
                        mem_we    <= 1'b0;
                    end else begin
                        mem_addr  <= i + 8'd1;
                        mem_wdata <= i + 8'd1;
                        mem_we    <= 1'b1;
                    end
                end
                RD_I: begin
                    state <= CAP_I;
                end
                CAP_I: begin
                    si       <= mem_rdata;
                    j        <= j_next;
                    mem_addr <= j_next;
                    state    <= RD_J;
                end
                RD_J: begin
                    state <= CAP_J;
                end
                CAP_J: begin
                    mem_addr  <= i;
                    mem_wdata <= mem_rdata;
                    mem_we    <= 1'b1;
                    state     <= WR_I;
                end
                WR_I: begin
                    mem_addr  <= j;
                    mem_wdata <= si;
                    mem_we    <= 1'b1;
                    state     <= WR_J;
                end
                WR_J: begin
                    mem_wdata <= '0;
                    mem_we    <= 1'b0;
                    if (i == 8'hFF) begin
                        mem_addr <= '0;
                        busy     <= 1'b0;
                        done     <= 1'b1;
                        state    <= DONE;
                    end else begin
                        i        <= i + 8'd1;
                        kidx     <= (kidx == KLAST) ? '0 : kidx + 1'b1;
                        mem_addr <= i + 8'd1;
                        state    <= RD_I;
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    state  <= IDLE;
                    mem_we <= 1'b0;
                    busy   <= 1'b0;
                    done   <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rc4_ksa_engine.sv
// Directed bench for rc4_ksa_engine: three configurations, each with its own
// behavioural 1-cycle-latency RAM, checked against a software KSA.
module tb_rc4_ksa_engine;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst;
    logic         start  [3];
    logic [127:0] key_v  [3];
    logic [7:0]   addr   [3];
    logic [7:0]   wdata  [3];
    logic [7:0]   rdata  [3];
    logic         we     [3];
    logic         busy   [3];
    logic         done   [3];
    logic         load   [3];
    logic [7:0]   mem    [3][256];
    logic [7:0]   init_mem [256];
    logic [7:0]   ref_s  [256];
    logic [7:0]   snap   [256];

    int total = 0;
    int bad   = 0;

    int         r_done_cyc;
    int         r_busy_bad;
    int         r_wd_bad;
    int         w_cyc  [$];
    logic [7:0] w_addr [$];
    logic [7:0] w_data [$];

    // d=0: KEY_BYTES=3 with fill; d=1: KEY_BYTES=1 preloaded; d=2: KEY_BYTES=16 with fill
    rc4_ksa_engine #(.KEY_BYTES(3), .FILL_EN(1'b1)) u3 (
        .clk(clk), .rst(rst), .start(start[0]), .secret_key(key_v[0][23:0]),
        .mem_rdata(rdata[0]), .mem_addr(addr[0]), .mem_wdata(wdata[0]),
        .mem_we(we[0]), .busy(busy[0]), .done(done[0])
    );
    rc4_ksa_engine #(.KEY_BYTES(1), .FILL_EN(1'b0)) u1 (
        .clk(clk), .rst(rst), .start(start[1]), .secret_key(key_v[1][7:0]),
        .mem_rdata(rdata[1]), .mem_addr(addr[1]), .mem_wdata(wdata[1]),
        .mem_we(we[1]), .busy(busy[1]), .done(done[1])
    );
    rc4_ksa_engine #(.KEY_BYTES(16), .FILL_EN(1'b1)) u16 (
        .clk(clk), .rst(rst), .start(start[2]), .secret_key(key_v[2]),
        .mem_rdata(rdata[2]), .mem_addr(addr[2]), .mem_wdata(wdata[2]),
        .mem_we(we[2]), .busy(busy[2]), .done(done[2])
    );

    always @(posedge clk) begin
        for (int d = 0; d < 3; d++) begin
            if (load[d]) begin
                for (int k = 0; k < 256; k++) mem[d][k] <= init_mem[k];
            end else if (we[d]) begin
                mem[d][addr[d]] <= wdata[d];
            end
            rdata[d] <= mem[d][addr[d]];
        end
    end

    task automatic preload(input int d, input bit identity);
        for (int k = 0; k < 256; k++) init_mem[k] = identity ? 8'(k) : 8'($urandom_range(0, 255));
        @(negedge clk);
        load[d] = 1'b1;
        @(negedge clk);
        load[d] = 1'b0;
    endtask

    task automatic ref_ksa(input int kb, input logic [127:0] key, input bit fill);
        logic [7:0] jj, t, kbyte;
        logic [127:0] sh;
        for (int k = 0; k < 256; k++) ref_s[k] = fill ? 8'(k) : init_mem[k];
        jj = 8'd0;
        for (int n = 0; n < 256; n++) begin
            sh    = key >> (8 * (kb - 1 - (n % kb)));
            kbyte = sh[7:0];
            jj    = jj + ref_s[n] + kbyte;
            t        = ref_s[n];
            ref_s[n] = ref_s[jj];
            ref_s[jj] = t;
        end
    endtask

    // Starts a run on instance d and records writes until done, stop_at or timeout
    task automatic do_run(input int d, input logic [127:0] key, input bit hold, input int stop_at);
        r_done_cyc = -1;
        r_busy_bad = 0;
        r_wd_bad   = 0;
        w_cyc.delete();
        w_addr.delete();
        w_data.delete();
        @(negedge clk);
        key_v[d] = key;
        start[d] = 1'b1;
        @(posedge clk);
        #1;
        if (!hold) start[d] = 1'b0;
        for (int c = 1; c <= 2000; c++) begin
            @(negedge clk);
            if (we[d]) begin
                w_cyc.push_back(c);
                w_addr.push_back(addr[d]);
                w_data.push_back(wdata[d]);
            end else if (wdata[d] !== 8'd0) begin
                r_wd_bad++;
            end
            if (done[d] === 1'b1) begin
                if (busy[d] !== 1'b0) r_busy_bad++;
                r_done_cyc = c;
                break;
            end else if (busy[d] !== 1'b1) begin
                r_busy_bad++;
            end
            if (hold && c == 500) key_v[d] = ~key;
            if (c == stop_at) break;
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        for (int d = 0; d < 3; d++) begin
            start[d] = 1'b0;
            load[d]  = 1'b0;
            key_v[d] = '0;
        end
        repeat (3) @(negedge clk);
        for (int d = 0; d < 3; d++) begin
            total++;
            if ({addr[d], wdata[d], we[d], busy[d], done[d]} !== 19'd0) begin
                bad++;
                $display("FAIL reset_outputs[%0d]: addr=%h wdata=%h we=%b busy=%b done=%b, want all 0",
                         d, addr[d], wdata[d], we[d], busy[d], done[d]);
            end
        end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_fill;
        int n_fill, pat_bad, last_c;
        preload(0, 1'b0);
        ref_ksa(3, 128'h010203, 1'b1);
        do_run(0, 128'h010203, 1'b0, 0);
        n_fill = 0; pat_bad = 0; last_c = -1;
        foreach (w_cyc[n]) begin
            if (w_cyc[n] <= 256) begin
                n_fill++;
                if (w_addr[n] !== 8'(w_cyc[n] - 1) || w_data[n] !== 8'(w_cyc[n] - 1)) pat_bad++;
                if (w_addr[n] === 8'hFF) last_c = w_cyc[n];
            end
        end
        total++;
        if (n_fill != 256) begin
            bad++; $display("FAIL fill_count: got %0d writes in cycles 1..256, want 256", n_fill);
        end
        total++;
        if (pat_bad != 0) begin
            bad++; $display("FAIL fill_pattern: %0d writes with addr/data != cycle-1, want 0", pat_bad);
        end
        total++;
        if (last_c != 256) begin
            bad++; $display("FAIL fill_last: addr 255 written at cycle %0d, want 256", last_c);
        end
        total++;
        if (r_done_cyc != 1793) begin
            bad++; $display("FAIL fill_latency: done at cycle %0d, want 1793", r_done_cyc);
        end
        total++;
        if (w_cyc.size() != 768) begin
            bad++; $display("FAIL fill_total_writes: got %0d, want 768", w_cyc.size());
        end
        total++;
        if (r_busy_bad != 0 || r_wd_bad != 0) begin
            bad++; $display("FAIL fill_busy_wdata: busy errors %0d wdata errors %0d, want 0 0", r_busy_bad, r_wd_bad);
        end
        begin
            int nerr = 0;
            for (int k = 0; k < 256; k++) if (mem[0][k] !== ref_s[k]) nerr++;
            total++;
            if (nerr != 0) begin
                bad++; $display("FAIL fill_image: %0d bytes differ from reference KSA, want 0", nerr);
            end
        end
        @(negedge clk);
        total++;
        if (done[0] !== 1'b0 || busy[0] !== 1'b0) begin
            bad++; $display("FAIL fill_done_once: done=%b busy=%b after DONE, want 0 0", done[0], busy[0]);
        end
    endtask

    // Uses the write log left by test_fill (key 0x010203)
    task automatic test_first_iters;
        int         exp_c [8] = '{261, 262, 267, 268, 273, 274, 279, 280};
        logic [7:0] exp_a [8] = '{8'd0, 8'd1, 8'd1, 8'd3, 8'd2, 8'd8, 8'd3, 8'd9};
        logic [7:0] exp_d [8] = '{8'd1, 8'd0, 8'd3, 8'd0, 8'd8, 8'd2, 8'd9, 8'd0};
        for (int e = 0; e < 8; e++) begin
            logic [7:0] ga, gd;
            bit found = 1'b0;
            ga = 8'hxx; gd = 8'hxx;
            foreach (w_cyc[n]) if (w_cyc[n] == exp_c[e]) begin found = 1'b1; ga = w_addr[n]; gd = w_data[n]; end
            total++;
            if (!found || ga !== exp_a[e] || gd !== exp_d[e]) begin
                bad++;
                $display("FAIL iter_write[%0d]: cycle %0d found=%0b s[%h]=%h, want s[%h]=%h",
                         e, exp_c[e], found, ga, gd, exp_a[e], exp_d[e]);
            end
        end
    endtask

    task automatic test_i_eq_j;
        int         exp_c [6] = '{5, 6, 11, 12, 17, 18};
        logic [7:0] exp_a [6] = '{8'd0, 8'd0, 8'd1, 8'd1, 8'd2, 8'd3};
        logic [7:0] exp_d [6] = '{8'd0, 8'd0, 8'd1, 8'd1, 8'd3, 8'd2};
        int nerr;
        preload(1, 1'b1);
        ref_ksa(1, 128'h00, 1'b0);
        do_run(1, 128'h00, 1'b0, 0);
        for (int e = 0; e < 6; e++) begin
            logic [7:0] ga, gd;
            bit found = 1'b0;
            ga = 8'hxx; gd = 8'hxx;
            foreach (w_cyc[n]) if (w_cyc[n] == exp_c[e]) begin found = 1'b1; ga = w_addr[n]; gd = w_data[n]; end
            total++;
            if (!found || ga !== exp_a[e] || gd !== exp_d[e]) begin
                bad++;
                $display("FAIL ij_write[%0d]: cycle %0d found=%0b s[%h]=%h, want s[%h]=%h",
                         e, exp_c[e], found, ga, gd, exp_a[e], exp_d[e]);
            end
        end
        total++;
        if (r_done_cyc != 1537) begin
            bad++; $display("FAIL ij_latency: done at cycle %0d, want 1537", r_done_cyc);
        end
        nerr = 0;
        for (int k = 0; k < 256; k++) if (mem[1][k] !== ref_s[k]) nerr++;
        total++;
        if (nerr != 0) begin
            bad++; $display("FAIL ij_image: %0d bytes differ from reference KSA, want 0", nerr);
        end
    endtask

    task automatic test_full_runs;
        int kbs  [3] = '{3, 1, 16};
        int lat  [3] = '{1793, 1537, 1793};
        bit fils [3] = '{1'b1, 1'b0, 1'b1};
        for (int d = 0; d < 3; d++) begin
            logic [127:0] key;
            int nerr;
            key = {$urandom, $urandom, $urandom, $urandom};
            preload(d, !fils[d]);
            ref_ksa(kbs[d], key, fils[d]);
            do_run(d, key, 1'b0, 0);
            total++;
            if (r_done_cyc != lat[d]) begin
                bad++; $display("FAIL full_latency[kb=%0d]: done at cycle %0d, want %0d", kbs[d], r_done_cyc, lat[d]);
            end
            nerr = 0;
            for (int k = 0; k < 256; k++) if (mem[d][k] !== ref_s[k]) nerr++;
            total++;
            if (nerr != 0) begin
                bad++; $display("FAIL full_image[kb=%0d]: %0d bytes differ from reference KSA, want 0", kbs[d], nerr);
            end
            total++;
            if (r_busy_bad != 0 || r_wd_bad != 0) begin
                bad++; $display("FAIL full_busy_wdata[kb=%0d]: busy errors %0d wdata errors %0d, want 0 0",
                                kbs[d], r_busy_bad, r_wd_bad);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_start_held;
        int nerr;
        preload(0, 1'b0);
        ref_ksa(3, 128'hA5C31E, 1'b1);
        do_run(0, 128'hA5C31E, 1'b1, 0);
        total++;
        if (r_done_cyc != 1793) begin
            bad++; $display("FAIL held_latency: done at cycle %0d, want 1793", r_done_cyc);
        end
        nerr = 0;
        for (int k = 0; k < 256; k++) if (mem[0][k] !== ref_s[k]) nerr++;
        total++;
        if (nerr != 0) begin
            bad++; $display("FAIL held_image: %0d bytes differ from KSA with captured key, want 0", nerr);
        end
        @(negedge clk);
        total++;
        if (busy[0] !== 1'b0 || done[0] !== 1'b0) begin
            bad++; $display("FAIL held_idle_gap: busy=%b done=%b in cycle after DONE, want 0 0", busy[0], done[0]);
        end
        @(negedge clk);
        total++;
        if (busy[0] !== 1'b1) begin
            bad++; $display("FAIL held_restart: busy=%b after IDLE with start high, want 1", busy[0]);
        end
        start[0] = 1'b0;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset_abort;
        int nerr;
        preload(0, 1'b0);
        do_run(0, 128'h0F1E2D, 1'b0, 800);
        rst = 1'b1;
        @(negedge clk);
        total++;
        if (we[0] !== 1'b0 || busy[0] !== 1'b0 || done[0] !== 1'b0) begin
            bad++; $display("FAIL abort_outputs: we=%b busy=%b done=%b after reset, want 0 0 0", we[0], busy[0], done[0]);
        end
        for (int k = 0; k < 256; k++) snap[k] = mem[0][k];
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        nerr = 0;
        for (int k = 0; k < 256; k++) if (mem[0][k] !== snap[k]) nerr++;
        total++;
        if (nerr != 0 || busy[0] !== 1'b0) begin
            bad++; $display("FAIL abort_quiet: %0d RAM bytes changed, busy=%b, want 0 and 0", nerr, busy[0]);
        end
        ref_ksa(3, 128'h3C5A96, 1'b1);
        do_run(0, 128'h3C5A96, 1'b0, 0);
        total++;
        if (r_done_cyc != 1793) begin
            bad++; $display("FAIL abort_rerun_latency: done at cycle %0d, want 1793", r_done_cyc);
        end
        nerr = 0;
        for (int k = 0; k < 256; k++) if (mem[0][k] !== ref_s[k]) nerr++;
        total++;
        if (nerr != 0) begin
            bad++; $display("FAIL abort_rerun_image: %0d bytes differ from reference KSA, want 0", nerr);
        end
    endtask

    initial begin
        test_reset;
        test_fill;
        test_first_iters;
        test_i_eq_j;
        test_full_runs;
        test_start_held;
        test_reset_abort;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/rc4_ksa_engine.md
Name: rc4_ksa_engine

Overview:
Self-sequencing RC4 key-scheduling engine. It is the parametrised successor of the shuffle datapath, with the controller and datapath merged into one block.
- Optionally fills the 256-byte S-box with the identity permutation.
- Then runs the full 256-iteration KSA swap loop against an external single-port 256x8 RAM with 1-cycle read latency.
- Key length is parametrised.
- Start/done handshake; sits between the top-level key source and the S-box RAM, ahead of the PRGA stage.

Parameters:
KEY_BYTES, 3, key length in bytes (1..16); key byte 0 is the MS byte of secret_key.
FILL_EN, 1, 1: run the identity fill pass before shuffling; 0: skip fill (RAM preloaded externally).

Ports:
clk  in  1  clock
rst  in  1  reset; synchronous, active-high
start  in  1  request to run; sampled only in IDLE
secret_key  in  8*KEY_BYTES  key; captured on the accepted start
mem_rdata  in  8  RAM read data; valid 1 cycle after address presented
mem_addr  out  8  RAM address
mem_wdata  out  8  RAM write data
mem_we  out  1  RAM write enable
busy  out  1  high while the engine is running
done  out  1  1-cycle pulse on completion

Behaviour:
- Reset: state=IDLE; i=0, j=0, key register=0. Outputs: mem_addr=0, mem_wdata=0, mem_we=0, busy=0, done=0.
- Reset mid-operation takes effect the next edge: mem_we=0 immediately, no further writes, RAM contents left as-is.
- Outputs are decoded from registered state/counters only. There is no combinational path from mem_rdata to any output.
- IDLE: on start=1, capture secret_key, set i=0, j=0, kidx=0. Next state is FILL if FILL_EN=1, else RD_I.
- busy=1 in every state except IDLE and DONE. start while busy is ignored.
- FILL: mem_addr=i, mem_wdata=i, mem_we=1, i increments each cycle.
  - After the i=255 write, i wraps to 0 and the state goes to RD_I.
  - The fill pass takes 256 cycles.
- Shuffle loop, 6 cycles per iteration:
  - RD_I: mem_addr=i.
  - CAP_I: latch si=mem_rdata; j <= j + si + key_byte[kidx] (8-bit, mod 256).
  - RD_J: mem_addr=j (new value).
  - CAP_J: latch sj=mem_rdata.
  - WR_I: mem_addr=i, mem_wdata=sj, mem_we=1.
  - WR_J: mem_addr=j, mem_wdata=si, mem_we=1.
    - If i==255, go to DONE.
    - Otherwise i <= i+1, kidx <= (kidx==KEY_BYTES-1) ? 0 : kidx+1, go to RD_I.
- Key byte select: key_byte[k] = key_reg[8*(KEY_BYTES-1-k) +: 8], with kidx kept equal to i mod KEY_BYTES by a wrap counter, not a divider.
- Boundary i==j: both writes go to the same address with the same value (si==sj). The result is a no-op and must not corrupt the entry.
- Counter widths: i is 8 bits. Termination is detected on i==255 in WR_J, so there is no 9-bit counter.
- DONE: done=1, busy=0 for exactly one cycle, then IDLE. start in DONE is ignored.
- Latency from start-accept edge, start seen at cycle 0:
  - FILL_EN=1: done at cycle 1793 (1 + 256 + 1536).
  - FILL_EN=0: done at cycle 1537.
- mem_wdata=0 whenever mem_we=0.

Test Plan:
- Fill, FILL_EN=1, key 0x010203 → cycles 1..256 write addr n / data n; addr 255 write at cycle 256; no other writes during fill.
- First iterations, same key → i=0: j=1, writes s[0]=1 then s[1]=0. i=1: j=3, writes s[1]=3 then s[3]=0. i=3 uses key byte 0x01 (kidx wrap).
- i==j case, KEY_BYTES=1, key 0x00 → i=0 and i=1 leave s[0]=0, s[1]=1. i=2: j=3, s[2]=3, s[3]=2. Final 256-byte RAM image must match the reference model.
- Full runs, random keys for KEY_BYTES=1,3,16 with FILL_EN=0 and FILL_EN=1 → final RAM image equals the software KSA. done pulses once, at cycle 1793 or 1537.
- start held high throughout and secret_key changed mid-run → single run using the key captured at accept; no restart until after DONE.
- rst asserted at cycle 800 → next cycle mem_we=0, busy=0, done=0. A fresh start afterwards completes correctly with i and j restarted from 0.
